// File: rtl/chroma_button_cmd.sv
// chroma_button_cmd: turns raw up/down/mode push-buttons into clean up/down command
// pulses with hold-to-repeat, plus the chroma/tone mode selection lines.
module chroma_button_cmd #(
   parameter int DEB_CYCLES    = 500000,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000,
   parameter int CNT_W         = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   input  logic       btn_mode_raw,
   output logic       up_pulse,
   output logic       down_pulse,
   output logic       tono_sel,
   output logic       color_sel,
   output logic       lp_sel,
   output logic [1:0] mode_o
);
   typedef enum logic [1:0] {IDLE, TONO, COLOR_L, COLOR_P} mode_t;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   // Button vectors are indexed 0 = up, 1 = down, 2 = mode.
   logic [2:0]            s1_q, s2_q, deb_q, deb_d, prev_q, rise;
   logic [2:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]            lock_q, lock_d, hold_q, hold_d, rep_q, rep_d, due, fire;
   logic [1:0][CNT_W-1:0] hcnt_q, hcnt_d;
   logic [1:0]            pulse_q;
   logic [2:0]            sel_q, sel_d;
   logic                  both, active;
   mode_t                 mode_q, mode_d;
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         deb_d[i]     = deb_q[i];
         deb_cnt_d[i] = '0;
         if (s2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = s2_q[i];
            else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
         end
      end
   end
   assign rise   = deb_q & ~prev_q;
   assign both   = deb_q[0] & deb_q[1];
   assign active = mode_q != IDLE;
   assign mode_d = !rise[2] ? mode_q : (mode_q == COLOR_P) ? TONO : mode_t'(mode_q + 2'd1);
   assign sel_d  = {mode_d == TONO, mode_d == COLOR_L || mode_d == COLOR_P, mode_d == COLOR_L};
   // A direction is locked while held together with the other one or across a mode press;
   // the lock only drops once that direction is released.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         lock_d[d] = deb_q[d] & (lock_q[d] | both | rise[2]);
         due[d]    = hold_q[d] & (hcnt_q[d] == (rep_q[d] ? REP_LAST : HOLD_LAST));
         fire[d]   = deb_q[d] & ~lock_d[d] & active & (rise[d] | due[d]);
         hold_d[d] = deb_q[d] & ~lock_d[d] & active & (fire[d] | hold_q[d]);
         rep_d[d]  = hold_d[d] & (fire[d] ? hold_q[d] : rep_q[d]);
         hcnt_d[d] = (hold_d[d] & ~fire[d]) ? hcnt_q[d] + 1'b1 : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         deb_q     <= '0;
         prev_q    <= '0;
         deb_cnt_q <= '0;
         lock_q    <= '0;
         hold_q    <= '0;
         rep_q     <= '0;
         hcnt_q    <= '0;
         pulse_q   <= '0;
         sel_q     <= '0;
         mode_q    <= IDLE;
      end else begin
         s1_q      <= {btn_mode_raw, btn_down_raw, btn_up_raw};
         s2_q      <= s1_q;
         deb_q     <= deb_d;
         prev_q    <= deb_q;
         deb_cnt_q <= deb_cnt_d;
         lock_q    <= lock_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         hcnt_q    <= hcnt_d;
         pulse_q   <= fire;
         sel_q     <= sel_d;
         mode_q    <= mode_d;
      end
   end
   assign up_pulse   = pulse_q[0];
   assign down_pulse = pulse_q[1];
   assign tono_sel   = sel_q[2];
   assign color_sel  = sel_q[1];
   assign lp_sel     = sel_q[0];
   assign mode_o     = mode_q;
endmodule

// File: tb/tb_chroma_button_cmd.sv
// tb_chroma_button_cmd: directed bench for chroma_button_cmd with short debounce/hold/repeat times.
module tb_chroma_button_cmd;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0;
   logic       up_pulse, down_pulse, tono_sel, color_sel, lp_sel;
   logic [1:0] mode_o;
   int vectors = 0, miscompares = 0, cyc = 0, both_cnt = 0;
   int upq[$], dnq[$];
   int c0;

   chroma_button_cmd #(.DEB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .CNT_W(25)) dut (
      .clk(clk), .reset(reset),
      .btn_up_raw(btn_up), .btn_down_raw(btn_down), .btn_mode_raw(btn_mode),
      .up_pulse(up_pulse), .down_pulse(down_pulse),
      .tono_sel(tono_sel), .color_sel(color_sel), .lp_sel(lp_sel), .mode_o(mode_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (up_pulse) upq.push_back(cyc);
      if (down_pulse) dnq.push_back(cyc);
      if (up_pulse && down_pulse) both_cnt++;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press_mode(input int pm, input int m, input int sel);
      btn_mode = 1'b1;
      ticks(6);
      chk("mode_before_latency", int'(mode_o), pm);
      tick();
      chk("mode_after_latency", int'(mode_o), m);
      chk("sel_lines", int'({tono_sel, color_sel, lp_sel}), sel);
      ticks(3);
      btn_mode = 1'b0;
      ticks(10);
   endtask

   initial begin
      // reset with every button pressed
      btn_up = 1'b1; btn_down = 1'b1; btn_mode = 1'b1;
      ticks(3);
      chk("reset_mode", int'(mode_o), 0);
      chk("reset_outs", int'({up_pulse, down_pulse, tono_sel, color_sel, lp_sel}), 0);
      reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
      upq.delete(); dnq.delete();
      ticks(10);
      chk("post_reset_pulses", upq.size() + dnq.size(), 0);
      chk("post_reset_mode", int'(mode_o), 0);

      // mode walk
      press_mode(0, 1, 3'b100);
      press_mode(1, 2, 3'b011);
      press_mode(2, 3, 3'b010);
      press_mode(3, 1, 3'b100);

      // debounce reject in TONO
      upq.delete();
      repeat (5) begin
         btn_up = 1'b1; ticks(2);
         btn_up = 1'b0; ticks(2);
      end
      ticks(10);
      chk("glitch_no_pulse", upq.size(), 0);
      c0 = cyc;
      btn_up = 1'b1;
      ticks(12);
      chk("clean_up_count", upq.size(), 1);
      chk("clean_up_latency", upq[0] - c0, 7);
      btn_up = 1'b0;
      ticks(12);
      chk("clean_up_single", upq.size(), 1);

      // auto-repeat in COLOR_L
      press_mode(1, 2, 3'b011);
      upq.delete();
      c0 = cyc;
      btn_up = 1'b1;
      ticks(60);
      btn_up = 1'b0;
      ticks(30);
      chk("repeat_count", upq.size(), 6);
      chk("repeat_p0", upq[0] - c0, 7);
      chk("repeat_p1", upq[1] - c0, 27);
      chk("repeat_p2", upq[2] - c0, 35);
      chk("repeat_p3", upq[3] - c0, 43);
      chk("repeat_p4", upq[4] - c0, 51);
      chk("repeat_p5", upq[5] - c0, 59);

      // simultaneous up/down in TONO
      press_mode(2, 3, 3'b010);
      press_mode(3, 1, 3'b100);
      upq.delete(); dnq.delete();
      btn_up = 1'b1; btn_down = 1'b1;
      ticks(40);
      chk("simul_no_pulse", upq.size() + dnq.size(), 0);
      btn_down = 1'b0;
      ticks(20);
      chk("simul_up_locked", upq.size() + dnq.size(), 0);
      btn_up = 1'b0;
      ticks(10);
      c0 = cyc;
      btn_up = 1'b1;
      ticks(12);
      chk("simul_repress_count", upq.size(), 1);
      chk("simul_repress_latency", upq[0] - c0, 7);
      btn_up = 1'b0;
      ticks(10);

      // IDLE ignores up; mode press while down is held locks down
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
      ticks(2);
      chk("rereset_mode", int'(mode_o), 0);
      upq.delete(); dnq.delete();
      btn_up = 1'b1;
      ticks(15);
      chk("idle_no_pulse", upq.size(), 0);
      btn_up = 1'b0;
      ticks(10);
      press_mode(0, 1, 3'b100);
      upq.delete(); dnq.delete();
      c0 = cyc;
      btn_down = 1'b1;
      ticks(27);
      chk("held_down_count", dnq.size(), 2);
      chk("held_down_repeat", dnq[1] - c0, 27);
      btn_mode = 1'b1;
      ticks(7);
      chk("held_mode_advance", int'(mode_o), 2);
      ticks(3);
      btn_mode = 1'b0;
      ticks(40);
      chk("held_down_locked", dnq.size(), 2);
      btn_down = 1'b0;
      ticks(10);
      c0 = cyc;
      btn_down = 1'b1;
      ticks(12);
      chk("down_repress_count", dnq.size(), 3);
      chk("down_repress_latency", dnq[2] - c0, 7);
      btn_down = 1'b0;
      ticks(10);
      chk("up_never_in_held_test", upq.size(), 0);
      chk("never_both_pulses", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/chroma_button_cmd.md
Name: chroma_button_cmd

Overview:
Front-end command generator for the chroma/tone adjust path. It turns the three raw board push-buttons (up, down, mode) into clean single-cycle up/down command pulses and level-type selection lines (tono_sel, color_sel, lp_sel). It sits between the board pins and the chroma control block. Processing per button: synchroniser, debouncer, edge detector, hold-to-repeat, plus a mode-select state machine.

Parameters:
DEB_CYCLES, 500000, consecutive stable clock cycles needed to accept a debounced level change (10 ms at 50 MHz)
HOLD_CYCLES, 25000000, cycles a button must stay held after its first pulse before auto-repeat starts
REPEAT_CYCLES, 5000000, auto-repeat pulse period once repeat is active
CNT_W, 25, width of the internal counters; must hold the largest parameter value minus 1

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
btn_up_raw  in  1  raw up button, asynchronous, active-high
btn_down_raw  in  1  raw down button, asynchronous, active-high
btn_mode_raw  in  1  raw mode button, asynchronous, active-high
up_pulse  out  1  one-cycle increment command
down_pulse  out  1  one-cycle decrement command
tono_sel  out  1  tone adjust selected
color_sel  out  1  colour adjust selected
lp_sel  out  1  when color_sel=1: 1 = text colour (L), 0 = background colour (P)
mode_o  out  2  current mode: 0=IDLE, 1=TONO, 2=COLOR_L, 3=COLOR_P

Behaviour:
- Reset state:
  - All outputs 0, mode IDLE.
  - Synchroniser flops, debounced levels and counters all 0.
  - Lockout flags cleared.
  - Reset has priority over every other event on the same edge. Asserting reset mid-debounce or mid-repeat aborts the operation with no pulse emitted.
- Synchroniser: each raw input passes through 2 flops (s1, s2).
- Debouncer, per button:
  - Counter increments while s2 != debounced level.
  - Counter clears to 0 on any cycle where s2 == debounced level.
  - When the counter reaches DEB_CYCLES-1 and s2 still differs, the debounced level takes s2 and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles are discarded.
- Edge detect: a press event is a 0->1 transition of the debounced level, registered. Latency from a clean raw rising edge to the pulse/mode change is exactly DEB_CYCLES+3 clocks.
- Mode FSM:
  - Advances on each mode press event: IDLE -> TONO -> COLOR_L -> COLOR_P -> TONO. IDLE is left only by the first press and is re-entered only by reset.
  - tono_sel = (TONO); color_sel = (COLOR_L or COLOR_P); lp_sel = (COLOR_L). All three are registered and decoded from the state only.
  - Mode release has no effect.
- Up/down pulses:
  - In IDLE, up/down press events are ignored and no pulses are produced.
  - In any other mode, an up press event with debounced down = 0 gives up_pulse = 1 for exactly one cycle. Down is symmetric.
- Auto-repeat (per direction, held alone):
  - A hold counter starts at the first pulse.
  - The second pulse occurs HOLD_CYCLES cycles after the first, then every REPEAT_CYCLES cycles while still held.
  - Debounced release stops repeat immediately and clears the counter.
- Simultaneous up and down:
  - Both debounced high in the same cycle (including press events on the same edge) gives no pulses, and both directions are locked out.
  - A locked-out direction emits nothing until its debounced level returns to 0. A fresh press is then required.
- Mode press while up/down is held:
  - Mode advances.
  - The held direction is locked out: no further repeat pulses until it is released and pressed again.
- up_pulse and down_pulse are never high in the same cycle.

Test Plan:
(Parameters for the bench: DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.)
- Reset check: assert reset 3 cycles with all buttons pressed, then release -> all outputs 0, mode_o=0, no pulses in the 10 cycles after release.
- Mode walk: 4 clean mode presses (each held 10 cycles, released 10) -> mode_o goes 1,2,3,1. Selection lines match each mode: (tono,color,lp) = 100, 011, 010, 100. Each change happens exactly 7 clocks after the raw rise.
- Debounce reject: in TONO, up pulses of 2 high / 2 low repeated 20 cycles -> zero up_pulse. A clean up press then gives exactly one up_pulse, 7 clocks after the raw rise.
- Auto-repeat: in COLOR_L, hold up for 60 cycles post-debounce -> up_pulse at relative cycles 0, 20, 28, 36, 44, 52. Nothing after debounced release.
- Simultaneous press: in TONO, raise up and down on the same edge and hold 40 cycles -> no pulses. Release down only -> still no up_pulse. Release and re-press up -> one up_pulse.
- IDLE / mode-while-held: after reset, press up -> no pulse. Enter TONO and hold down past the first repeat, then press mode -> mode_o becomes 2 and no further down_pulse until down is re-pressed.
